// File: rtl/gem_trigger_rx_deframer.sv
// Trigger-link RX deframer: aligns on the per-BX comma, checks link integrity,
// recovers 4 clusters + BC0/overflow per frame, tracks lock and orbit spacing.
module gem_trigger_rx_deframer #(
  parameter int LOCK_FRAMES  = 32,
  parameter int UNLOCK_ERRS  = 4,
  parameter int BX_PER_ORBIT = 3564,
  parameter int ERRCNT_W     = 16
) (
  input  logic                clk_160,
  input  logic                reset_i,
  input  logic [15:0]         rx_data,
  input  logic [1:0]          rx_charisk,
  input  logic [1:0]          rx_disperr,
  input  logic [1:0]          rx_notintable,
  output logic [13:0]         cluster0,
  output logic [13:0]         cluster1,
  output logic [13:0]         cluster2,
  output logic [13:0]         cluster3,
  output logic [3:0]          valid_clusters,
  output logic                bc0,
  output logic                overflow,
  output logic                frame_valid,
  output logic                locked,
  output logic [ERRCNT_W-1:0] frame_err_cnt,
  output logic [ERRCNT_W-1:0] bc0_err_cnt,
  output logic [ERRCNT_W-1:0] lock_loss_cnt,
  input  logic                cnt_clear
);

  localparam int GW  = $clog2(LOCK_FRAMES + 1);
  localparam int BW  = $clog2(UNLOCK_ERRS + 1);
  localparam int BXW = $clog2(BX_PER_ORBIT);
  localparam logic [GW-1:0]  GOOD_LAST = GW'(LOCK_FRAMES - 1);
  localparam logic [BW-1:0]  BAD_LAST  = BW'(UNLOCK_ERRS - 1);
  localparam logic [BXW-1:0] BX_LAST   = BXW'(BX_PER_ORBIT - 1);

  typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_t;

  state_t         state, state_nxt;
  logic [1:0]     phase;
  logic           bad_acc;
  logic [39:0]    d_sh;
  logic           sh_bc0, sh_ovf;
  logic [GW-1:0]  good_cnt;
  logic [BW-1:0]  bad_cnt;
  logic [BXW-1:0] bx_cnt;
  logic           bc0_seen;

  // comma decode on the low byte
  logic k_ok, k_bc0, k_ovf, comma_ok, word_err, word_bad;
  always_comb begin
    k_ok  = 1'b1;
    k_bc0 = 1'b0;
    k_ovf = 1'b0;
    case (rx_data[7:0])
      8'hBC: ;
      8'hF7: k_bc0 = 1'b1;
      8'hFC: k_ovf = 1'b1;
      8'h1C: begin k_bc0 = 1'b1; k_ovf = 1'b1; end
      default: k_ok = 1'b0;
    endcase
  end

  assign comma_ok = k_ok && (rx_charisk == 2'b01);
  assign word_err = |{rx_disperr, rx_notintable};
  assign word_bad = (phase == 2'd0) ? (!comma_ok || word_err)
                                    : (|rx_charisk || word_err);

  logic        frame_done, frame_bad;
  logic [55:0] frame_d;
  assign frame_done = (state != HUNT) && (phase == 2'd3);
  assign frame_bad  = bad_acc || word_bad;
  assign frame_d    = {rx_data, d_sh};

  // FSM control strobes
  logic good_clr, good_inc, bad_clr, bad_inc;
  logic out_en, frame_err_inc, lock_loss_inc;

  always_ff @(posedge clk_160 or posedge reset_i) begin
    if (reset_i) state <= HUNT;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    good_clr      = 1'b0;
    good_inc      = 1'b0;
    bad_clr       = 1'b0;
    bad_inc       = 1'b0;
    out_en        = 1'b0;
    frame_err_inc = 1'b0;
    lock_loss_inc = 1'b0;
    case (state)
      HUNT: begin
        if (comma_ok && !word_err) begin
          state_nxt = SYNC;
          good_clr  = 1'b1;
        end
      end
      SYNC: begin
        if (frame_done) begin
          if (frame_bad) begin
            state_nxt = HUNT;
          end else begin
            good_inc = 1'b1;
            if (good_cnt == GOOD_LAST) begin
              state_nxt = LOCKED;
              out_en    = 1'b1;
              bad_clr   = 1'b1;
            end
          end
        end
      end
      LOCKED: begin
        if (frame_done) begin
          if (frame_bad) begin
            bad_inc       = 1'b1;
            frame_err_inc = 1'b1;
            if (bad_cnt == BAD_LAST) begin
              state_nxt     = HUNT;
              lock_loss_inc = 1'b1;
            end
          end else begin
            bad_clr = 1'b1;
            out_en  = 1'b1;
          end
        end
      end
      default: state_nxt = HUNT;
    endcase
  end

  assign locked = (state == LOCKED);

  // HUNT parks phase at 0; the word after a comma is phase 1
  always_ff @(posedge clk_160 or posedge reset_i) begin
    if (reset_i)              phase <= 2'd0;
    else if (state == HUNT)   phase <= (comma_ok && !word_err) ? 2'd1 : 2'd0;
    else                      phase <= phase + 2'd1;
  end

  always_ff @(posedge clk_160 or posedge reset_i) begin
    if (reset_i)                              bad_acc <= 1'b0;
    else if (state == HUNT || phase == 2'd3)  bad_acc <= 1'b0;
    else                                      bad_acc <= bad_acc | word_bad;
  end

  // payload of words 0..2 held until word3 completes the frame
  always_ff @(posedge clk_160 or posedge reset_i) begin
    if (reset_i) begin
      d_sh   <= '0;
      sh_bc0 <= 1'b0;
      sh_ovf <= 1'b0;
    end else begin
      case (phase)
        2'd0: begin
          d_sh[7:0] <= rx_data[15:8];
          sh_bc0    <= k_bc0;
          sh_ovf    <= k_ovf;
        end
        2'd1:    d_sh[23:8]  <= rx_data;
        2'd2:    d_sh[39:24] <= rx_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_160 or posedge reset_i) begin
    if (reset_i) begin
      good_cnt <= '0;
      bad_cnt  <= '0;
    end else begin
      if (good_clr)      good_cnt <= '0;
      else if (good_inc) good_cnt <= good_cnt + GW'(1);
      if (bad_clr)       bad_cnt  <= '0;
      else if (bad_inc)  bad_cnt  <= bad_cnt + BW'(1);
    end
  end

  // orbit tracking runs for every frame completed in (or into) LOCKED
  logic frame_counted, bc0_err_inc;
  assign frame_counted = frame_done && (state_nxt == LOCKED);
  assign bc0_err_inc   = out_en && sh_bc0 && bc0_seen && (bx_cnt != BX_LAST);

  always_ff @(posedge clk_160 or posedge reset_i) begin
    if (reset_i) begin
      bx_cnt   <= '0;
      bc0_seen <= 1'b0;
    end else if (state_nxt != LOCKED) begin
      bx_cnt   <= '0;
      bc0_seen <= 1'b0;
    end else if (frame_counted) begin
      if (out_en && sh_bc0) begin
        bx_cnt   <= '0;
        bc0_seen <= 1'b1;
      end else begin
        bx_cnt <= (bx_cnt == BX_LAST) ? '0 : bx_cnt + BXW'(1);
      end
    end
  end

  logic [3:0][13:0] clus_nxt;
  logic [3:0]       vc_nxt;
  assign clus_nxt = frame_d;
  always_comb begin
    vc_nxt = '0;
    for (int i = 0; i < 4; i++) vc_nxt[i] = ~(clus_nxt[i][10:9] == 2'b11);
  end

  always_ff @(posedge clk_160 or posedge reset_i) begin
    if (reset_i) begin
      cluster0       <= '0;
      cluster1       <= '0;
      cluster2       <= '0;
      cluster3       <= '0;
      valid_clusters <= '0;
      bc0            <= 1'b0;
      overflow       <= 1'b0;
      frame_valid    <= 1'b0;
    end else begin
      frame_valid <= out_en;
      if (out_en) begin
        cluster0       <= clus_nxt[0];
        cluster1       <= clus_nxt[1];
        cluster2       <= clus_nxt[2];
        cluster3       <= clus_nxt[3];
        valid_clusters <= vc_nxt;
        bc0            <= sh_bc0;
        overflow       <= sh_ovf;
      end
    end
  end

  function automatic logic [ERRCNT_W-1:0] sat_step(input logic [ERRCNT_W-1:0] c,
                                                   input logic clr, input logic inc);
    if (clr)                  return '0;
    else if (inc && ~&c)      return c + ERRCNT_W'(1);
    else                      return c;
  endfunction

  always_ff @(posedge clk_160 or posedge reset_i) begin
    if (reset_i) begin
      frame_err_cnt <= '0;
      bc0_err_cnt   <= '0;
      lock_loss_cnt <= '0;
    end else begin
      frame_err_cnt <= sat_step(frame_err_cnt, cnt_clear, frame_err_inc);
      bc0_err_cnt   <= sat_step(bc0_err_cnt,   cnt_clear, bc0_err_inc);
      lock_loss_cnt <= sat_step(lock_loss_cnt, cnt_clear, lock_loss_inc);
    end
  end

endmodule

// File: tb/tb_gem_trigger_rx_deframer.sv
// Directed bench for the trigger-link deframer: lock, error handling, orbit
// check, comma variants, counter clear and async reset.
module tb_gem_trigger_rx_deframer;

  logic        clk_160 = 1'b0;
  logic        reset_i = 1'b1;
  logic [15:0] rx_data = '0;
  logic [1:0]  rx_charisk = '0, rx_disperr = '0, rx_notintable = '0;
  logic        cnt_clear = 1'b0;
  logic [13:0] cluster0, cluster1, cluster2, cluster3;
  logic [3:0]  valid_clusters;
  logic        bc0, overflow, frame_valid, locked;
  logic [15:0] frame_err_cnt, bc0_err_cnt, lock_loss_cnt;

  gem_trigger_rx_deframer dut (
    .clk_160(clk_160), .reset_i(reset_i), .rx_data(rx_data),
    .rx_charisk(rx_charisk), .rx_disperr(rx_disperr), .rx_notintable(rx_notintable),
    .cluster0(cluster0), .cluster1(cluster1), .cluster2(cluster2), .cluster3(cluster3),
    .valid_clusters(valid_clusters), .bc0(bc0), .overflow(overflow),
    .frame_valid(frame_valid), .locked(locked), .frame_err_cnt(frame_err_cnt),
    .bc0_err_cnt(bc0_err_cnt), .lock_loss_cnt(lock_loss_cnt), .cnt_clear(cnt_clear)
  );

  always #3 clk_160 = ~clk_160;

  localparam logic [55:0] D0 = 56'h0123456789ABCD;
  localparam logic [55:0] D1 = 56'hFEDCBA98765432;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic word(input logic [15:0] d, input logic [1:0] k);
    rx_data = d; rx_charisk = k; rx_disperr = 2'b00; rx_notintable = 2'b00;
    @(posedge clk_160); #1;
  endtask

  // bad_ph: phase carrying disperr (or notintable if use_nit); k_ph: phase with stray K flag
  task automatic frame(input logic [7:0] kc, input logic [55:0] d,
                       input int bad_ph = -1, input bit use_nit = 1'b0,
                       input int k_ph = -1, input bit clr = 1'b0);
    for (int p = 0; p < 4; p++) begin
      case (p)
        0:       rx_data = {d[7:0], kc};
        1:       rx_data = d[23:8];
        2:       rx_data = d[39:24];
        default: rx_data = d[55:40];
      endcase
      rx_charisk    = (p == 0) ? 2'b01 : ((p == k_ph) ? 2'b01 : 2'b00);
      rx_disperr    = (p == bad_ph && !use_nit) ? 2'b01 : 2'b00;
      rx_notintable = (p == bad_ph &&  use_nit) ? 2'b10 : 2'b00;
      cnt_clear     = clr && (p == 3);
      @(posedge clk_160); #1;
    end
    cnt_clear = 1'b0;
  endtask

  bit saw_fv;

  initial begin
    #10;
    chk("rst_locked", locked, 0);
    chk("rst_fv", frame_valid, 0);
    chk("rst_c0", cluster0, 0);
    chk("rst_vc", valid_clusters, 0);
    chk("rst_ferr", frame_err_cnt, 0);
    reset_i = 1'b0;
    @(posedge clk_160); #1;

    // misaligned start: tail of a frame, word2 carrying a high-byte K flag
    word(16'h3CBC, 2'b10);
    word(D0[55:40], 2'b00);
    chk("mis_locked", locked, 0);

    saw_fv = 1'b0;
    for (int i = 1; i <= 31; i++) begin
      frame(8'hBC, D0);
      if (frame_valid) saw_fv = 1'b1;
    end
    chk("pre_lock_locked", locked, 0);
    chk("pre_lock_no_fv", saw_fv, 0);
    frame(8'hBC, D0);
    chk("lock32_locked", locked, 1);
    chk("lock32_fv", frame_valid, 1);
    chk("c0", cluster0, 14'h2BCD);
    chk("c1", cluster1, 14'h1E26);
    chk("c2", cluster2, 14'h3456);
    chk("c3", cluster3, 14'h0048);
    chk("vc", valid_clusters, 4'hD);
    chk("bc0_norm", bc0, 0);
    chk("ovf_norm", overflow, 0);
    for (int i = 33; i <= 40; i++) begin
      frame(8'hBC, D0);
      chk("fv_locked", frame_valid, 1);
    end

    // error handling while locked
    for (int i = 0; i < 3; i++) begin
      frame(8'hBC, D0, 1);
      chk("bad_no_fv", frame_valid, 0);
    end
    chk("ferr3", frame_err_cnt, 3);
    chk("locked_after3", locked, 1);
    frame(8'hBC, D0);
    chk("good_fv", frame_valid, 1);
    frame(8'hBC, D0, 0);
    chk("bad_no_fv", frame_valid, 0);
    frame(8'hBC, D0, 2, 1'b1);
    chk("bad_no_fv", frame_valid, 0);
    frame(8'hBC, D0, -1, 1'b0, 3);
    chk("bad_no_fv", frame_valid, 0);
    chk("locked_after_3bad", locked, 1);
    chk("ferr6", frame_err_cnt, 6);
    frame(8'h55, D0);
    chk("bad_no_fv", frame_valid, 0);
    chk("unlock", locked, 0);
    chk("ferr7", frame_err_cnt, 7);
    chk("lockloss1", lock_loss_cnt, 1);

    // relock then orbit check
    for (int i = 1; i <= 31; i++) frame(8'hBC, D0);
    chk("relock_pre", locked, 0);
    frame(8'hBC, D0);
    chk("relock", locked, 1);
    frame(8'hF7, D0);
    chk("bc0_first", bc0, 1);
    chk("bc0_first_fv", frame_valid, 1);
    frame(8'hBC, D0);
    chk("bc0_clears", bc0, 0);
    for (int o = 0; o < 3; o++) begin
      repeat (3562) frame(8'hBC, D0);
      frame(8'hF7, D0);
      chk("bc0_orbit", bc0, 1);
      chk("bc0_orbit_fv", frame_valid, 1);
      if (o < 2) frame(8'hBC, D0);
    end
    chk("bc0err0", bc0_err_cnt, 0);
    repeat (3562) frame(8'hBC, D0);
    frame(8'hF7, D0);
    chk("bc0err1", bc0_err_cnt, 1);

    // comma variants
    frame(8'hFC, D0);
    chk("fc_ovf", overflow, 1);
    chk("fc_bc0", bc0, 0);
    chk("fc_fv", frame_valid, 1);
    frame(8'h1C, D0);
    chk("1c_ovf", overflow, 1);
    chk("1c_bc0", bc0, 1);
    chk("1c_bc0err", bc0_err_cnt, 2);
    frame(8'h3C, D0);
    chk("3c_no_fv", frame_valid, 0);
    chk("3c_ferr", frame_err_cnt, 8);

    // clear wins over a coincident increment
    frame(8'hBC, D0, 1, 1'b0, -1, 1'b1);
    chk("clr_ferr", frame_err_cnt, 0);
    chk("clr_bc0err", bc0_err_cnt, 0);
    chk("clr_lockloss", lock_loss_cnt, 0);
    chk("clr_locked", locked, 1);

    frame(8'hBC, D1);
    chk("d1_c0", cluster0, 14'h1432);
    chk("d1_c3", cluster3, 14'h3FB7);
    frame(8'hBC, D1, 2);
    chk("pre_rst_ferr", frame_err_cnt, 1);

    // async reset mid-frame
    word({D0[7:0], 8'hBC}, 2'b01);
    word(D0[23:8], 2'b00);
    #1 reset_i = 1'b1;
    #1;
    chk("arst_c0", cluster0, 0);
    chk("arst_c3", cluster3, 0);
    chk("arst_vc", valid_clusters, 0);
    chk("arst_locked", locked, 0);
    chk("arst_ferr", frame_err_cnt, 0);
    #1 reset_i = 1'b0;
    @(posedge clk_160); #1;
    for (int i = 1; i <= 31; i++) frame(8'hBC, D0);
    chk("arst_relock_pre", locked, 0);
    frame(8'hBC, D0);
    chk("arst_relock", locked, 1);
    chk("arst_relock_c0", cluster0, 14'h2BCD);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
